// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter: shares the register file write port between ALU (port 0) and
// load (port 1) writeback, with aging for port 1 and one-stage read bypass.
module regs_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr0_valid,
  output logic        wr0_ready,
  input  logic [4:0]  wr0_addr,
  input  logic [31:0] wr0_data,
  input  logic        wr1_valid,
  output logic        wr1_ready,
  input  logic [4:0]  wr1_addr,
  input  logic [31:0] wr1_data,
  output logic        rf_RegWrite,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  input  logic [4:0]  rd_addrs,
  input  logic [4:0]  rd_addrt,
  input  logic [31:0] rf_read_data1,
  input  logic [31:0] rf_read_data2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt;
  logic        starve;
  logic        acc0, acc1;
  logic        issue_we;
  logic [4:0]  issue_addr;
  logic [31:0] issue_data;
  logic        byp1, byp2;
  logic [31:0] byp1_data, byp2_data;

  assign starve    = (wait_cnt == MaxWait);
  assign wr1_ready = !wr0_valid || starve;
  assign wr0_ready = !(starve && wr1_valid);
  assign acc0      = wr0_valid && wr0_ready;
  assign acc1      = wr1_valid && wr1_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    issue_we   = 1'b0;
    issue_addr = rf_write_addr;
    issue_data = rf_write_data;
    if (acc1) begin
      issue_we   = (wr1_addr != 5'd0);
      issue_addr = wr1_addr;
      issue_data = wr1_data;
    end else if (acc0) begin
      issue_we   = (wr0_addr != 5'd0);
      issue_addr = wr0_addr;
      issue_data = wr0_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (!wr1_valid || acc1) begin
      wait_cnt <= 4'd0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // NOTE: the data registers are reset too so the outputs are defined straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_RegWrite   <= 1'b0;
      rf_write_addr <= 5'd0;
      rf_write_data <= 32'd0;
    end else begin
      rf_RegWrite   <= issue_we;
      rf_write_addr <= issue_addr;
      rf_write_data <= issue_data;
    end
  end

  // The write committing at this edge is invisible to the register file's read
  // captured at the same edge, so remember it for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp1      <= 1'b0;
      byp2      <= 1'b0;
      byp1_data <= 32'd0;
      byp2_data <= 32'd0;
    end else begin
      byp1      <= rf_RegWrite && (rf_write_addr == rd_addrs);
      byp2      <= rf_RegWrite && (rf_write_addr == rd_addrt);
      byp1_data <= rf_write_data;
      byp2_data <= rf_write_data;
    end
  end

  assign read_data1 = byp1 ? byp1_data : rf_read_data1;
  assign read_data2 = byp2 ? byp2_data : rf_read_data2;

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Port 0: ALU writeback.
  - Port 1: load writeback.
- Uses fixed priority with anti-starvation aging.
- Drives the register file's RegWrite / write_addr / write_data from registered outputs.
- Forwards same-edge writes onto the register file's registered read outputs, so the core never sees stale read data.
- Sits between the writeback stage and the register file.

Parameters:
- MAX_WAIT, 4: number of consecutive stalled cycles on port 1 before port 1 gets priority for one grant. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr0_valid  in  1  port 0 write request
- wr0_ready  out  1  port 0 accepted this cycle when valid & ready
- wr0_addr  in  5  port 0 destination register
- wr0_data  in  32  port 0 write data
- wr1_valid  in  1  port 1 write request
- wr1_ready  out  1  port 1 accept
- wr1_addr  in  5  port 1 destination register
- wr1_data  in  32  port 1 write data
- rf_RegWrite  out  1  register file write enable (registered)
- rf_write_addr  out  5  register file write address (registered)
- rf_write_data  out  32  register file write data (registered)
- rd_addrs  in  5  read address s, also wired to the register file addrs
- rd_addrt  in  5  read address t, also wired to the register file addrt
- rf_read_data1  in  32  register file read_data1
- rf_read_data2  in  32  register file read_data2
- read_data1  out  32  corrected read data s
- read_data2  out  32  corrected read data t

Behaviour:
- Reset (async, immediate):
  - rf_RegWrite=0, rf_write_addr=0, rf_write_data=0.
  - wait_cnt=0, byp1/byp2 flags=0, bypass data regs=0.
  - read_data1/2 then equal rf_read_data1/2.
- Wait counter (4 bits):
  - Increments each cycle with wr1_valid & !wr1_ready, saturating at MAX_WAIT.
  - Clears on a port 1 accept or when wr1_valid=0.
  - starve = (wait_cnt == MAX_WAIT).
- Ready (combinational; never depends on the port's own valid):
  - wr1_ready = !wr0_valid | starve.
  - wr0_ready = !(starve & wr1_valid).
  - At most one accept per cycle.
- Write issue:
  - An accept in cycle N produces rf_RegWrite=1 with that addr/data in cycle N+1.
  - The register file commits at the end of N+1.
  - No accept in N gives rf_RegWrite=0 in N+1; addr/data hold their last values.
- Register 0 protection:
  - An accepted write with addr==0 is consumed: ready/accept as normal.
  - It still produces rf_RegWrite=0 in N+1; r0 stays 0.
- Handshake:
  - A requester holds valid/addr/data stable until accepted.
  - The arbiter never drops an accepted request.
  - Back-to-back accepts give one write per cycle; throughput is 1 write/cycle.
- Bypass (one-stage, matches the register file's 1-cycle registered read):
  - At each rising edge: byp1 <= rf_RegWrite & (rf_write_addr == rd_addrs); byp1_data <= rf_write_data. Likewise byp2 for rd_addrt.
  - read_data1 = byp1 ? byp1_data : rf_read_data1; read_data2 likewise.
  - Both bypasses may be active at once, including with the same address on both.
  - Register 0 is never bypassed, because rf_RegWrite is never 1 for addr 0.
- Simultaneous events:
  - Both valid and starve=0: port 0 wins.
  - Both valid and starve=1: port 1 wins; the counter clears the next cycle.
- Reset mid-operation:
  - A pending write is discarded (rf_RegWrite=0 immediately); bypass flags clear.
  - Requesters re-present after reset.

Test Plan:
- Reset: assert rst mid-cycle while rf_RegWrite=1 -> rf_RegWrite drops to 0 without a clock edge; read_data1 equals rf_read_data1.
- Single write: wr0 addr=5, data=0xDEADBEEF accepted in cycle N -> rf_RegWrite=1, rf_write_addr=5, rf_write_data=0xDEADBEEF in N+1 only; r5 reads 0xDEADBEEF from N+3 onward.
- Priority/aging with MAX_WAIT=4: wr0 valid every cycle, wr1 valid addr=7, data=0x11 -> wr1_ready=0 for 4 cycles, wr1_ready=1 and wr0_ready=0 on the 5th; the register file sees the r7 write one cycle later; port 0 resumes after.
- Bypass: rf_RegWrite=1 addr=9 data=0x1234 in cycle N with rd_addrs=rd_addrt=9 in N -> read_data1=read_data2=0x1234 in N+1 despite the stale rf_read_data; rd_addrs=10 -> no bypass.
- R0: wr1 addr=0, data=0xFFFFFFFF accepted -> wr1_ready=1, rf_RegWrite stays 0; reading r0 returns 0, no bypass.
- Back-to-back: wr0 writes r1..r4 on consecutive cycles -> four consecutive rf_RegWrite pulses, in order, with no gaps.
